// File: rtl/uart_pkg.sv
// uart_pkg: frame constants, transmit FSM states and parity helper shared by the UART paths.
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
   localparam int UART_DATA_BITS = 8;
   function automatic logic uart_parity(input logic [7:0] b, input logic odd);
      return (^b) ^ odd;
   endfunction
endpackage

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: byte valid/ready handshake into the UART transmitter.
interface uart_transmitter_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   modport master (output tx_data, tx_valid, input tx_ready);
   modport slave (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: per-bit cycle counter, pulses bit_done on the last clock of each line bit.
module uart_baud_gen #(
   parameter int BIT_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic restart,
   output logic bit_done
);
   localparam int W = $clog2(BIT_CYCLES);
   localparam logic [W-1:0] LAST = W'(BIT_CYCLES - 1);
   logic [W-1:0] cnt;
   assign bit_done = enable && cnt == LAST;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else cnt <= (!enable || restart || bit_done) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises bytes as start, 8 data bits LSB first, optional parity, 1-2 stop bits.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 9600,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic clk,
   input  logic rst,
   uart_transmitter_if.slave bus,
   output logic tx,
   output logic state_busy
);
   localparam int BIT_CYCLES = CLK_FREQ / BAUD;
   if (BIT_CYCLES < 2) begin : g_bit_cycles_chk
      $error("uart_transmitter: BIT_CYCLES must be >= 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_bits_chk
      $error("uart_transmitter: STOP_BITS must be 1 or 2");
   end
   uart_tx_state_t state;
   logic [7:0] sh;
   logic       par;
   logic [2:0] idx;
   logic       stop_idx;
   logic       bit_done;
   logic       accept;
   assign bus.tx_ready = state == IDLE;
   assign state_busy = state != IDLE;
   assign accept = bus.tx_valid && bus.tx_ready;
   uart_baud_gen #(.BIT_CYCLES(BIT_CYCLES)) u_baud (
      .clk(clk),
      .rst(rst),
      .enable(state_busy),
      .restart(accept),
      .bit_done(bit_done)
   );
   // tx is loaded one bit ahead from sh[1], so sh shifts as each data bit completes
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         tx <= 1'b1;
         sh <= '0;
         par <= 1'b0;
         idx <= '0;
         stop_idx <= 1'b0;
      end else
         case (state)
            IDLE:
               if (accept) begin
                  state <= START;
                  tx <= 1'b0;
                  sh <= bus.tx_data;
                  par <= uart_parity(bus.tx_data, 1'(PARITY_ODD));
                  idx <= '0;
                  stop_idx <= 1'b0;
               end
            START:
               if (bit_done) begin
                  state <= DATA;
                  tx <= sh[0];
               end
            DATA:
               if (bit_done) begin
                  if (idx == 3'(UART_DATA_BITS - 1)) begin
                     state <= PARITY_EN != 0 ? PARITY : STOP;
                     tx <= PARITY_EN != 0 ? par : 1'b1;
                  end else begin
                     idx <= idx + 3'd1;
                     sh <= {1'b0, sh[7:1]};
                     tx <= sh[1];
                  end
               end
            PARITY:
               if (bit_done) begin
                  state <= STOP;
                  tx <= 1'b1;
               end
            STOP:
               if (bit_done) begin
                  if (stop_idx == 1'(STOP_BITS - 1)) state <= IDLE;
                  else stop_idx <= 1'b1;
               end
            default: state <= IDLE;
         endcase
endmodule
